scan_counter_2d: RTL and testbench

//   Parametrised 2-D coordinate scanner: walks (x,y) over a runtime-sized

---
 rtl/scan_counter_2d.sv | 154 +++++++++++++++
 tb/tb_scan_counter_2d.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_counter_2d.sv
// scan_counter_2d
//   2-D coordinate scanner. After an accepted start it walks (x,y) over the
//   rectangle [0..x_limit] x [0..y_limit] and emits one coordinate per
//   un-stalled cycle. A one-cycle done pulse follows the final coordinate.
//   Used as the address/sequence generator for tile and frame walkers.
//
// Build option
//   SCAN_SERPENTINE_EN  defined: boustrophedon order (odd rows run xl..0).
//                       undefined: raster order (every row runs 0..xl).
//
// Ports
//   clock    in   1             rising-edge clock
//   rst_n    in   1             synchronous active-low reset
//   start    in   1             begin a scan (sampled only in IDLE)
//   x_limit  in   WIDTH         last x (inclusive), latched on accepted start
//   y_limit  in   HEIGHT        last y (inclusive), latched on accepted start
//   stall    in   1             hold the current coordinate this cycle
//   busy     out  1             high in SCAN and DONE
//   valid    out  1             x/y/index hold a live coordinate
//   x        out  WIDTH         current x
//   y        out  HEIGHT        current y
//   index    out  WIDTH+HEIGHT  linear count of coordinates emitted, from 0
//   last     out  1             valid coordinate is the final one
//   done     out  1             one-cycle pulse after the final coordinate
//
// Handshake: start is a request seen only while IDLE; the first coordinate
// is valid the following cycle. A coordinate is consumed on every cycle in
// which valid=1 and stall=0; with stall=1 every output holds.
module scan_counter_2d #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 11
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH-1:0]          x_limit,
  input  logic [HEIGHT-1:0]         y_limit,
  input  logic                      stall,
  output logic                      busy,
  output logic                      valid,
  output logic [WIDTH-1:0]          x,
  output logic [HEIGHT-1:0]         y,
  output logic [WIDTH+HEIGHT-1:0]   index,
  output logic                      last,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]        X_ONE   = 1;
  localparam logic [HEIGHT-1:0]       Y_ONE   = 1;
  localparam logic [WIDTH+HEIGHT-1:0] IDX_ONE = 1;

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          x_q, x_d;
  logic [HEIGHT-1:0]         y_q, y_d;
  logic [WIDTH+HEIGHT-1:0]   index_q, index_d;
  logic [WIDTH-1:0]          xl_q, xl_d;
  logic [HEIGHT-1:0]         yl_q, yl_d;
  logic [WIDTH-1:0]          row_end_x;
  logic                      last_w;

  // Row-end x is where the current row finishes; odd rows run backwards
  // in the serpentine build.
`ifdef SCAN_SERPENTINE_EN
  assign row_end_x = y_q[0] ? '0 : xl_q;
`else
  assign row_end_x = xl_q;
`endif

  assign last_w = (state_q == SCAN) && (y_q == yl_q) && (x_q == row_end_x);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      index_q <= '0;
      xl_q    <= '0;
      yl_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      index_q <= index_d;
      xl_q    <= xl_d;
      yl_q    <= yl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    index_d = index_q;
    xl_d    = xl_q;
    yl_d    = yl_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          xl_d    = x_limit;
          yl_d    = y_limit;
          x_d     = '0;
          y_d     = '0;
          index_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!stall) begin
          if (last_w) begin
            state_d = DONE;
          end else begin
            index_d = index_q + IDX_ONE;
            if (x_q == row_end_x) begin
              y_d = y_q + Y_ONE;
`ifdef SCAN_SERPENTINE_EN
              // The new row is odd exactly when the current one is even.
              x_d = y_q[0] ? '0 : xl_q;
`else
              x_d = '0;
`endif
            end else begin
`ifdef SCAN_SERPENTINE_EN
              x_d = y_q[0] ? (x_q - X_ONE) : (x_q + X_ONE);
`else
              x_d = x_q + X_ONE;
`endif
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy  = (state_q == SCAN) || (state_q == DONE);
  assign valid = (state_q == SCAN);
  assign done  = (state_q == DONE);
  assign last  = last_w;
  assign x     = x_q;
  assign y     = y_q;
  assign index = index_q;

endmodule

// File: tb/tb_scan_counter_2d.sv
// tb_scan_counter_2d
//   Directed bench for scan_counter_2d (default WIDTH/HEIGHT). Expected
//   coordinates are hand-written tables; serpentine tables are selected
//   with SCAN_SERPENTINE_EN to match the build of the design.
module tb_scan_counter_2d;

  localparam int WIDTH  = 10;
  localparam int HEIGHT = 11;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                    rst_n;
  logic                    start;
  logic [WIDTH-1:0]        x_limit;
  logic [HEIGHT-1:0]       y_limit;
  logic                    stall;
  logic                    busy;
  logic                    valid;
  logic [WIDTH-1:0]        x;
  logic [HEIGHT-1:0]       y;
  logic [WIDTH+HEIGHT-1:0] index;
  logic                    last;
  logic                    done;

  int n_cmp = 0;
  int n_bad = 0;

  scan_counter_2d #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .start   (start),
    .x_limit (x_limit),
    .y_limit (y_limit),
    .stall   (stall),
    .busy    (busy),
    .valid   (valid),
    .x       (x),
    .y       (y),
    .index   (index),
    .last    (last),
    .done    (done)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_coord(input string tag, input int xe, input int ye,
                              input int ie, input int le);
    check({tag, " busy"},  int'(busy),  1);
    check({tag, " valid"}, int'(valid), 1);
    check({tag, " x"},     int'(x),     xe);
    check({tag, " y"},     int'(y),     ye);
    check({tag, " index"}, int'(index), ie);
    check({tag, " last"},  int'(last),  le);
    check({tag, " done"},  int'(done),  0);
  endtask

  task automatic expect_done(input string tag);
    check({tag, " busy"},  int'(busy),  1);
    check({tag, " valid"}, int'(valid), 0);
    check({tag, " last"},  int'(last),  0);
    check({tag, " done"},  int'(done),  1);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " busy"},  int'(busy),  0);
    check({tag, " valid"}, int'(valid), 0);
    check({tag, " last"},  int'(last),  0);
    check({tag, " done"},  int'(done),  0);
  endtask

  task automatic expect_reset(input string tag);
    expect_idle(tag);
    check({tag, " x"},     int'(x),     0);
    check({tag, " y"},     int'(y),     0);
    check({tag, " index"}, int'(index), 0);
  endtask

  // Expected coordinate tables
`ifdef SCAN_SERPENTINE_EN
  int t1_x[6] = '{0, 1, 2, 2, 1, 0};
  int t1_y[6] = '{0, 0, 0, 1, 1, 1};
  int t5_x[4] = '{0, 1, 1, 0};
  int t5_y[4] = '{0, 0, 1, 1};
  // 4x4 scan: coordinate (1,1) is reached at index 6
  int t4_x[7] = '{0, 1, 2, 3, 3, 2, 1};
  int t4_y[7] = '{0, 0, 0, 0, 1, 1, 1};
  int t4_n    = 7;
`else
  int t1_x[6] = '{0, 1, 2, 0, 1, 2};
  int t1_y[6] = '{0, 0, 0, 1, 1, 1};
  int t5_x[4] = '{0, 1, 0, 1};
  int t5_y[4] = '{0, 0, 1, 1};
  // 4x4 scan: coordinate (1,1) is reached at index 5
  int t4_x[7] = '{0, 1, 2, 3, 0, 1, 0};
  int t4_y[7] = '{0, 0, 0, 0, 1, 1, 0};
  int t4_n    = 6;
`endif

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    x_limit = '0;
    y_limit = '0;
    stall   = 1'b0;

    // Reset state
    step();
    step();
    expect_reset("reset");
    rst_n = 1'b1;
    step();
    expect_idle("idle_after_reset");

    // 1. 3x2 scan, no stall
    x_limit = 10'd2;
    y_limit = 11'd1;
    start   = 1'b1;
    step();
    start   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      expect_coord($sformatf("t1_c%0d", i), t1_x[i], t1_y[i], i, (i == 5) ? 1 : 0);
      step();
    end
    expect_done("t1_done");
    step();
    expect_idle("t1_idle");

    // 2. Degenerate 1x1 scan, then immediate re-start in the IDLE cycle
    x_limit = 10'd0;
    y_limit = 11'd0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    expect_coord("t2_c0", 0, 0, 0, 1);
    step();
    expect_done("t2_done");
    start = 1'b1;
    step();
    expect_idle("t2_idle");
    step();
    start = 1'b0;
    expect_coord("t2_restart_c0", 0, 0, 0, 1);
    step();
    expect_done("t2_restart_done");
    step();
    expect_idle("t2_restart_idle");

    // 3. 3x1 scan with a two-cycle stall at (1,0)
    x_limit = 10'd2;
    y_limit = 11'd0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    expect_coord("t3_c0", 0, 0, 0, 0);
    step();
    expect_coord("t3_c1", 1, 0, 1, 0);
    stall = 1'b1;
    step();
    expect_coord("t3_c1_hold1", 1, 0, 1, 0);
    step();
    expect_coord("t3_c1_hold2", 1, 0, 1, 0);
    stall = 1'b0;
    step();
    expect_coord("t3_c2", 2, 0, 2, 1);
    // A stall on the last coordinate holds it too.
    stall = 1'b1;
    step();
    expect_coord("t3_c2_hold", 2, 0, 2, 1);
    stall = 1'b0;
    step();
    expect_done("t3_done");
    step();
    expect_idle("t3_idle");

    // 4. Reset in the middle of a 4x4 scan at (1,1)
    x_limit = 10'd3;
    y_limit = 11'd3;
    start   = 1'b1;
    step();
    start   = 1'b0;
    for (int i = 0; i < t4_n; i++) begin
      expect_coord($sformatf("t4_c%0d", i), t4_x[i], t4_y[i], i, 0);
      if (i < t4_n - 1) step();
    end
    rst_n = 1'b0;
    step();
    expect_reset("t4_reset");
    rst_n = 1'b1;
    step();
    expect_idle("t4_no_done");
    start = 1'b1;
    step();
    start = 1'b0;
    expect_coord("t4_restart_c0", 0, 0, 0, 0);
    step();
    expect_coord("t4_restart_c1", 1, 0, 1, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    expect_reset("t4_cleanup");

    // 5. start and x_limit changes are ignored during a 2x2 scan
    x_limit = 10'd1;
    y_limit = 11'd1;
    start   = 1'b1;
    step();
    x_limit = 10'd7;
    for (int i = 0; i < 4; i++) begin
      expect_coord($sformatf("t5_c%0d", i), t5_x[i], t5_y[i], i, (i == 3) ? 1 : 0);
      step();
    end
    expect_done("t5_done");
    start = 1'b0;
    step();
    expect_idle("t5_idle");
    step();
    expect_idle("t5_no_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
